quad_lane_accumulator: RTL and testbench

//  Four-lane (A/B/C/D) 32-bit accumulator stage. Sits directly upstream of the carry-out/overflow

---
 rtl/quad_lane_accumulator.sv | 134 +++++++++++++
 tb/tb_quad_lane_accumulator.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/quad_lane_accumulator.sv
// Four-lane 32-bit accumulator: sums BEATS handshaked beats per frame, then holds the
// per-lane result, sticky carry and one-shot scale flag until downstream accepts it.

module qla_lane #(
  parameter bit SCALE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] op_in,
  output logic [31:0] acc,
  output logic        carry,
  output logic        scaled
);
  logic [31:0] op;
  logic [32:0] sum;

  // Once a lane has halved itself, later operands are halved to stay on the same scale.
  always_comb begin
    op  = scaled ? {1'b0, op_in[31:1]} : op_in;
    sum = {1'b0, acc} + {1'b0, op};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      carry  <= 1'b0;
      scaled <= 1'b0;
    end else if (clr) begin
      acc    <= '0;
      carry  <= 1'b0;
      scaled <= 1'b0;
    end else if (en) begin
      if (!sum[32]) begin
        acc <= sum[31:0];
      end else if (SCALE_EN && !scaled) begin
        acc    <= sum[32:1];
        scaled <= 1'b1;
      end else begin
        acc   <= sum[31:0];
        carry <= 1'b1;
      end
    end
  end
endmodule

module quad_lane_accumulator #(
  parameter int BEATS    = 4,
  parameter bit SCALE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic [31:0] c_in,
  input  logic [31:0] d_in,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [31:0] C,
  output logic [31:0] D,
  output logic        A32,
  output logic        B32,
  output logic        C32,
  output logic        D32,
  output logic        SRA,
  output logic        SRB,
  output logic        SRC,
  output logic        SRD,
  output logic        out_valid,
  input  logic        out_ready
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 32;
  localparam int CW        = $clog2(BEATS + 1);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  state_t state_q, state_d;

  logic [CW-1:0]                     cnt;
  logic                              clr, beat, last;
  logic [NUM_LANES-1:0][VEC_W-1:0]   lane_in, lane_acc;
  logic [NUM_LANES-1:0]              lane_c, lane_s;

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign clr       = (state_q == IDLE) && start;
  assign beat      = in_ready && in_valid;
  assign last      = beat && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)     state_d = ACCUM;
      ACCUM:   if (last)      state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (beat) cnt <= cnt + 1'b1;
  end

  assign lane_in = {d_in, c_in, b_in, a_in};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    qla_lane #(.SCALE_EN(SCALE_EN)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .en     (beat),
      .op_in  (lane_in[l]),
      .acc    (lane_acc[l]),
      .carry  (lane_c[l]),
      .scaled (lane_s[l])
    );
  end

  assign {D, C, B, A}         = lane_acc;
  assign {D32, C32, B32, A32} = lane_c;
  assign {SRD, SRC, SRB, SRA} = lane_s;
endmodule

// File: tb/tb_quad_lane_accumulator.sv
// Randomized + directed bench: two instances (scaling on/off) share stimulus and are
// compared every cycle against an arithmetic frame model.

module tb_quad_lane_accumulator;
  localparam int BEATS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] din [4];

  logic [3:0][31:0] acc0, acc1;
  logic [3:0]       c0, c1, s0, s1;
  logic             ir0, ir1, ov0, ov1;

  int nchk = 0, nerr = 0;

  // model: index 0 = no scaling, 1 = scaling
  logic [31:0] m_acc [2][4];
  bit          m_c   [2][4];
  bit          m_s   [2][4];
  int          m_ph;   // 0 idle, 1 accumulating, 2 holding
  int          m_cnt;

  always #5 clk = ~clk;

  quad_lane_accumulator #(.BEATS(BEATS), .SCALE_EN(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(ir0),
    .a_in(din[0]), .b_in(din[1]), .c_in(din[2]), .d_in(din[3]),
    .A(acc0[0]), .B(acc0[1]), .C(acc0[2]), .D(acc0[3]),
    .A32(c0[0]), .B32(c0[1]), .C32(c0[2]), .D32(c0[3]),
    .SRA(s0[0]), .SRB(s0[1]), .SRC(s0[2]), .SRD(s0[3]),
    .out_valid(ov0), .out_ready(out_ready));

  quad_lane_accumulator #(.BEATS(BEATS), .SCALE_EN(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(ir1),
    .a_in(din[0]), .b_in(din[1]), .c_in(din[2]), .d_in(din[3]),
    .A(acc1[0]), .B(acc1[1]), .C(acc1[2]), .D(acc1[3]),
    .A32(c1[0]), .B32(c1[1]), .C32(c1[2]), .D32(c1[3]),
    .SRA(s1[0]), .SRB(s1[1]), .SRC(s1[2]), .SRD(s1[3]),
    .out_valid(ov1), .out_ready(out_ready));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_clear();
    for (int d = 0; d < 2; d++)
      for (int l = 0; l < 4; l++) begin
        m_acc[d][l] = '0; m_c[d][l] = 0; m_s[d][l] = 0;
      end
    m_cnt = 0;
  endtask

  task automatic m_lane(input int d, input int l, input logic [31:0] x);
    longint unsigned op, s;
    op = m_s[d][l] ? longint'(x) / 2 : longint'(x);
    s  = longint'(m_acc[d][l]) + op;
    if (s < 64'h1_0000_0000) m_acc[d][l] = 32'(s);
    else if (d == 1 && !m_s[d][l]) begin
      m_acc[d][l] = 32'(s / 2); m_s[d][l] = 1;
    end else begin
      m_acc[d][l] = 32'(s - 64'h1_0000_0000); m_c[d][l] = 1;
    end
  endtask

  task automatic m_step();
    case (m_ph)
      0: if (start) begin m_clear(); m_ph = 1; end
      1: if (in_valid) begin
           for (int d = 0; d < 2; d++)
             for (int l = 0; l < 4; l++) m_lane(d, l, din[l]);
           m_cnt++;
           if (m_cnt == BEATS) m_ph = 2;
         end
      default: if (out_ready) m_ph = 0;
    endcase
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d in_ready", d), d ? ir1 : ir0, m_ph == 1);
      chk($sformatf("d%0d out_valid", d), d ? ov1 : ov0, m_ph == 2);
      for (int l = 0; l < 4; l++) begin
        chk($sformatf("d%0d acc%0d", d, l), d ? acc1[l] : acc0[l], m_acc[d][l]);
        chk($sformatf("d%0d carry%0d", d, l), d ? c1[l] : c0[l], m_c[d][l]);
        chk($sformatf("d%0d scaled%0d", d, l), d ? s1[l] : s0[l], m_s[d][l]);
      end
    end
  endtask

  // inputs change only at posedge+1, so the model sees what the DUT sampled
  task automatic cyc();
    @(posedge clk);
    if (!rst) m_step();
    #1;
    check_all();
  endtask

  task automatic set_in(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] d);
    in_valid = v; din[0] = a; din[1] = b; din[2] = c; din[3] = d;
  endtask

  initial begin
    logic [31:0] held;
    for (int l = 0; l < 4; l++) din[l] = '0;
    m_clear(); m_ph = 0;
    #2; check_all();
    cyc(); cyc();
    rst = 1'b0;

    // plain sum, out_valid one cycle after the last beat
    start = 1; cyc(); start = 0;
    for (int i = 1; i <= 4; i++) begin set_in(1, 32'(i), 0, 0, 0); cyc(); end
    chk("sum A", acc1[0], 32'd10);
    chk("sum A32", c1[0], 1'b0);
    chk("sum out_valid", ov1, 1'b1);
    set_in(0, 0, 0, 0, 0); out_ready = 1; cyc(); out_ready = 0;
    chk("idle after accept", ov1, 1'b0);

    // asynchronous reset mid-frame
    start = 1; cyc(); start = 0;
    set_in(1, 7, 8, 9, 10); cyc(); cyc();
    #2 rst = 1'b1; #1;
    m_clear(); m_ph = 0;
    check_all();
    chk("rst A", acc1[0], 32'd0);
    chk("rst in_ready", ir1, 1'b0);
    set_in(0, 0, 0, 0, 0);
    cyc(); rst = 1'b0;
    start = 1; cyc(); start = 0;
    chk("restart in_ready", ir1, 1'b1);

    // scaling: FFFF_FFFF x3 then a zero beat
    for (int i = 0; i < 3; i++) begin
      set_in(1, 32'hFFFF_FFFF, 0, 0, 0); cyc();
      if (i == 1) begin
        chk("scale A beat2", acc1[0], 32'hFFFF_FFFF);
        chk("scale SRA beat2", s1[0], 1'b1);
      end
    end
    chk("scale A beat3", acc1[0], 32'h7FFF_FFFE);
    chk("scale A32 beat3", c1[0], 1'b1);
    set_in(1, 0, 0, 0, 0); cyc();
    set_in(0, 0, 0, 0, 0); out_ready = 1; cyc(); out_ready = 0;

    // carry without scaling is sticky
    start = 1; cyc(); start = 0;
    set_in(1, 0, 32'h8000_0000, 0, 0); cyc(); cyc();
    set_in(1, 0, 5, 0, 0); cyc();
    set_in(1, 0, 0, 0, 0); cyc();
    chk("noscale B", acc0[1], 32'd5);
    chk("noscale B32", c0[1], 1'b1);
    chk("noscale SRB", s0[1], 1'b0);
    set_in(0, 0, 0, 0, 0); out_ready = 1; cyc(); out_ready = 0;

    // gapped valid, held result stable while out_ready low
    start = 1; cyc(); start = 0;
    for (int i = 0; i < 7; i++) begin set_in(i % 2 == 0, 32'(i + 1), 32'(3 * i), 1, 2); cyc(); end
    set_in(0, 0, 0, 0, 0);
    held = acc1[0];
    chk("gap A", held, 32'd16);
    for (int i = 0; i < 3; i++) begin cyc(); chk("hold stable", acc1[0], held); end
    out_ready = 1; cyc(); out_ready = 0;
    chk("gap idle", ov1, 1'b0);

    // start ignored outside IDLE; C/D overflow alone
    start = 1; cyc(); start = 0;
    for (int i = 0; i < 4; i++) begin
      start = (i == 2);
      set_in(1, 1, 1, 32'hFFFF_FFFF, 32'hF000_0000); cyc();
    end
    start = 1; set_in(0, 0, 0, 0, 0); cyc(); start = 0;
    chk("indep SRC", s1[2], 1'b1);
    chk("indep SRD", s1[3], 1'b1);
    chk("indep SRA", s1[0], 1'b0);
    chk("indep A", acc1[0], 32'd4);
    out_ready = 1; cyc(); out_ready = 0;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      start     = ($urandom_range(0, 2) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      for (int l = 0; l < 4; l++)
        din[l] = $urandom_range(0, 1) ? ($urandom() | 32'hC000_0000) : $urandom();
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
